// File: rtl/ula_arbitro.sv
// Two-port arbiter that time-shares one external combinational ula (add/sub).
// Build option ULA_ARB_PRIORIDADE_FIXA_EN: porta 0 always wins on contention instead of round-robin.
//
// state    | meaning
// OCIOSO   | idle; arbitrates req0/req1, latches winner's operands on grant
// EXECUTA  | operands held on ula_a/ula_b/ula_sel, ula output settling
// RESPONDE | resultado valid, done pulse to the winner
module ula_arbitro #(
  parameter int LARGURA = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [LARGURA-1:0] a0,
  input  logic [LARGURA-1:0] b0,
  input  logic               sel0,
  output logic               done0,
  input  logic               req1,
  input  logic [LARGURA-1:0] a1,
  input  logic [LARGURA-1:0] b1,
  input  logic               sel1,
  output logic               done1,
  output logic [LARGURA-1:0] resultado,
  output logic               ocupado,
  output logic [LARGURA-1:0] ula_a,
  output logic [LARGURA-1:0] ula_b,
  output logic               ula_sel,
  input  logic [LARGURA-1:0] ula_saida
);

  typedef enum logic [1:0] {OCIOSO, EXECUTA, RESPONDE} estado_t;

  estado_t estado, proximo;
  logic    vencedor;
  logic    concede;
  logic    escolha;
`ifndef ULA_ARB_PRIORIDADE_FIXA_EN
  logic    ultimo;
`endif

  always_comb begin
    proximo = estado;
    concede = 1'b0;
    escolha = 1'b0;
    case (estado)
      OCIOSO: begin
        if (req0 || req1) begin
          concede = 1'b1;
          proximo = EXECUTA;
`ifdef ULA_ARB_PRIORIDADE_FIXA_EN
          escolha = ~req0;
`else
          // on contention the port that was not served last wins
          escolha = (req0 && req1) ? ~ultimo : req1;
`endif
        end
      end
      EXECUTA:  proximo = RESPONDE;
      RESPONDE: proximo = OCIOSO;
      default:  proximo = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado    <= OCIOSO;
      vencedor  <= 1'b0;
      ula_a     <= '0;
      ula_b     <= '0;
      ula_sel   <= 1'b0;
      resultado <= '0;
`ifndef ULA_ARB_PRIORIDADE_FIXA_EN
      ultimo    <= 1'b1;
`endif
    end else begin
      estado <= proximo;
      if (concede) begin
        vencedor <= escolha;
        ula_a    <= escolha ? a1 : a0;
        ula_b    <= escolha ? b1 : b0;
        ula_sel  <= escolha ? sel1 : sel0;
      end
      if (estado == EXECUTA) resultado <= ula_saida;
`ifndef ULA_ARB_PRIORIDADE_FIXA_EN
      if (estado == RESPONDE) ultimo <= vencedor;
`endif
    end
  end

  assign done0   = (estado == RESPONDE) && !vencedor;
  assign done1   = (estado == RESPONDE) &&  vencedor;
  assign ocupado = (estado != OCIOSO);

endmodule

// File: tb/tb_ula_arbitro.sv
// Self-checking bench for ula_arbitro: directed scenarios plus randomized traffic
// against a transaction-level model (grant cycle g -> done at g+2, next grant at g+3).
module tb_ula_arbitro;
  localparam int LARGURA = 16;

  logic               clk;
  logic               rst;
  logic               req0, req1;
  logic [LARGURA-1:0] a0, b0, a1, b1;
  logic               sel0, sel1;
  logic               done0, done1;
  logic [LARGURA-1:0] resultado;
  logic               ocupado;
  logic [LARGURA-1:0] ula_a, ula_b;
  logic               ula_sel;
  logic [LARGURA-1:0] ula_saida;

  int n_checks = 0;
  int n_fail   = 0;

  ula_arbitro #(.LARGURA(LARGURA)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .sel0(sel0), .done0(done0),
    .req1(req1), .a1(a1), .b1(b1), .sel1(sel1), .done1(done1),
    .resultado(resultado), .ocupado(ocupado),
    .ula_a(ula_a), .ula_b(ula_b), .ula_sel(ula_sel), .ula_saida(ula_saida)
  );

  // the external combinational ula
  assign ula_saida = ula_sel ? (ula_a - ula_b) : (ula_a + ula_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; sel0 = 1'b0; a1 = '0; b1 = '0; sel1 = 1'b0;
    tick(); tick();
    n_checks++;
    if ({done0, done1, ocupado} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got done0/done1/ocupado=%b expected 000", {done0, done1, ocupado});
    end
    n_checks++;
    if (resultado !== 16'h0000) begin
      n_fail++; $display("FAIL reset_resultado got %h expected 0000", resultado);
    end
    n_checks++;
    if ({ula_a, ula_b, ula_sel} !== 33'h0) begin
      n_fail++; $display("FAIL reset_ula got a=%h b=%h sel=%b expected zeros", ula_a, ula_b, ula_sel);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_add();
    req0 = 1'b1; a0 = 16'h0002; b0 = 16'h0003; sel0 = 1'b0;
    tick();
    n_checks++;
    if ({ula_a, ula_b, ula_sel, ocupado, done0} !== {16'h0002, 16'h0003, 1'b0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL add_grant got a=%h b=%h sel=%b ocup=%b done0=%b expected 0002 0003 0 1 0",
                         ula_a, ula_b, ula_sel, ocupado, done0);
    end
    // operands are changed after grant; they must not leak into the operation
    req0 = 1'b0; a0 = 16'h1234; b0 = 16'h9999; sel0 = 1'b1;
    tick();
    n_checks++;
    if ({done0, done1, resultado} !== {1'b1, 1'b0, 16'h0005}) begin
      n_fail++; $display("FAIL add_done got done0=%b done1=%b res=%h expected 1 0 0005", done0, done1, resultado);
    end
    tick();
    n_checks++;
    if ({done0, ocupado, resultado, ula_a} !== {1'b0, 1'b0, 16'h0005, 16'h0002}) begin
      n_fail++; $display("FAIL add_after got done0=%b ocup=%b res=%h ula_a=%h expected 0 0 0005 0002",
                         done0, ocupado, resultado, ula_a);
    end
  endtask

  task automatic test_single_sub();
    int n_ocup = 0, n_d1 = 0, n_d0 = 0;
    logic [LARGURA-1:0] r = '0;
    req1 = 1'b1; a1 = 16'h0004; b1 = 16'h0002; sel1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ocupado) n_ocup++;
      if (done0) n_d0++;
      if (done1) begin n_d1++; r = resultado; req1 = 1'b0; end
    end
    req1 = 1'b0;
    n_checks++;
    if (n_ocup != 2) begin
      n_fail++; $display("FAIL sub_ocupado got %0d busy cycles expected 2", n_ocup);
    end
    n_checks++;
    if (n_d1 != 1 || n_d0 != 0) begin
      n_fail++; $display("FAIL sub_done got done1 x%0d done0 x%0d expected 1 and 0", n_d1, n_d0);
    end
    n_checks++;
    if (r !== 16'h0002) begin
      n_fail++; $display("FAIL sub_result got %h expected 0002", r);
    end
  endtask

  task automatic test_contention();
    int ev_i[$];
    int ev_p[$];
    logic [LARGURA-1:0] ev_r[$];
    int exp_p;
    logic [LARGURA-1:0] exp_r;
    rst = 1'b1;
    req0 = 1'b1; a0 = 16'h0002; b0 = 16'h0003; sel0 = 1'b0;
    req1 = 1'b1; a1 = 16'h0004; b1 = 16'h0002; sel1 = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (done0) begin ev_i.push_back(i); ev_p.push_back(0); ev_r.push_back(resultado); end
      if (done1) begin ev_i.push_back(i); ev_p.push_back(1); ev_r.push_back(resultado); end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (ev_i.size() != 4) begin
      n_fail++; $display("FAIL cont_count got %0d done pulses expected 4", ev_i.size());
    end
    for (int k = 0; k < 4 && k < ev_i.size(); k++) begin
`ifdef ULA_ARB_PRIORIDADE_FIXA_EN
      exp_p = 0;
`else
      exp_p = k % 2;
`endif
      exp_r = (exp_p == 1) ? 16'h0002 : 16'h0005;
      n_checks++;
      if (ev_i[k] != 2 + 3 * k || ev_p[k] != exp_p || ev_r[k] !== exp_r) begin
        n_fail++; $display("FAIL cont_ev%0d got cycle=%0d port=%0d res=%h expected cycle=%0d port=%0d res=%h",
                           k, ev_i[k], ev_p[k], ev_r[k], 2 + 3 * k, exp_p, exp_r);
      end
    end
  endtask

  task automatic test_wrap();
    logic got;
    logic [LARGURA-1:0] r, exp_r;
    for (int k = 0; k < 2; k++) begin
      req0 = 1'b1;
      a0   = (k == 0) ? 16'hFFFF : 16'h0000;
      b0   = 16'h0001;
      sel0 = (k == 1);
      exp_r = (k == 0) ? 16'h0000 : 16'hFFFF;
      got = 1'b0; r = 'x;
      for (int i = 0; i < 6 && !got; i++) begin
        tick();
        if (done0) begin got = 1'b1; r = resultado; end
      end
      req0 = 1'b0;
      tick();
      n_checks++;
      if (!got || r !== exp_r) begin
        n_fail++; $display("FAIL wrap%0d got done=%b res=%h expected done=1 res=%h", k, got, r, exp_r);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    req0 = 1'b1; a0 = 16'h0007; b0 = 16'h0001; sel0 = 1'b0;
    tick();
    n_checks++;
    if (ocupado !== 1'b1) begin
      n_fail++; $display("FAIL rmid_busy got ocupado=%b expected 1", ocupado);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({done0, ocupado, resultado, ula_a} !== {1'b0, 1'b0, 16'h0000, 16'h0000}) begin
      n_fail++; $display("FAIL rmid_abort got done0=%b ocup=%b res=%h ula_a=%h expected 0 0 0000 0000",
                         done0, ocupado, resultado, ula_a);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({ula_a, done0, ocupado} !== {16'h0007, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL rmid_regrant got ula_a=%h done0=%b ocup=%b expected 0007 0 1", ula_a, done0, ocupado);
    end
    tick();
    n_checks++;
    if ({done0, resultado} !== {1'b1, 16'h0008}) begin
      n_fail++; $display("FAIL rmid_done got done0=%b res=%h expected 1 0008", done0, resultado);
    end
    req0 = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int g, wport, last;
    logic [LARGURA-1:0] wa, wb, wres, ea, eb, er;
    logic wsel, es, eo, ed0, ed1;
    bit w0, w1, inf0, inf1, win;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    tick();
    rst = 1'b0;
    g = -10; wport = 0; last = 1;
    wa = '0; wb = '0; wsel = 1'b0; wres = '0;
    ea = '0; eb = '0; es = 1'b0; er = '0;
    w0 = 1'b0; w1 = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (c == g + 1) begin ea = wa; eb = wb; es = wsel; end
      if (c == g + 2) er = wres;
      eo  = (c == g + 1) || (c == g + 2);
      ed0 = (c == g + 2) && (wport == 0);
      ed1 = (c == g + 2) && (wport == 1);
      n_checks++;
      if ({done0, done1} !== {ed0, ed1}) begin
        n_fail++; $display("FAIL rnd_done c=%0d got %b%b expected %b%b", c, done0, done1, ed0, ed1);
      end
      n_checks++;
      if (ocupado !== eo) begin
        n_fail++; $display("FAIL rnd_ocupado c=%0d got %b expected %b", c, ocupado, eo);
      end
      n_checks++;
      if (resultado !== er) begin
        n_fail++; $display("FAIL rnd_resultado c=%0d got %h expected %h", c, resultado, er);
      end
      n_checks++;
      if ({ula_a, ula_b, ula_sel} !== {ea, eb, es}) begin
        n_fail++; $display("FAIL rnd_ula c=%0d got %h %h %b expected %h %h %b", c, ula_a, ula_b, ula_sel, ea, eb, es);
      end

      inf0 = (wport == 0) && (c > g) && (c <= g + 2);
      inf1 = (wport == 1) && (c > g) && (c <= g + 2);
      a0 = 16'($urandom); b0 = 16'($urandom); sel0 = 1'($urandom_range(0, 1));
      a1 = 16'($urandom); b1 = 16'($urandom); sel1 = 1'($urandom_range(0, 1));
      if (w0) req0 = 1'b1;
      else begin
        req0 = ($urandom_range(0, 2) == 0);
        if (req0 && !inf0) w0 = 1'b1;
      end
      if (w1) req1 = 1'b1;
      else begin
        req1 = ($urandom_range(0, 2) == 0);
        if (req1 && !inf1) w1 = 1'b1;
      end

      if (c >= g + 3 && (req0 || req1)) begin
`ifdef ULA_ARB_PRIORIDADE_FIXA_EN
        win = !req0;
`else
        win = (req0 && req1) ? (last == 0) : req1;
`endif
        g     = c;
        wport = win ? 1 : 0;
        wa    = win ? a1 : a0;
        wb    = win ? b1 : b0;
        wsel  = win ? sel1 : sel0;
        wres  = wsel ? (wa - wb) : (wa + wb);
        last  = wport;
        if (win) w1 = 1'b0; else w0 = 1'b0;
      end
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_single_sub();
    test_contention();
    test_wrap();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_arbitro.md
Name: ula_arbitro

Overview:
- Shares a single `ula` instance between two requesters (porta 0, porta 1).
- Arbitrates requests round-robin, latches the winner's operands and drives the ULA operand/select ports from registers.
- Captures `saida` into a result register and pulses a per-requester done.
- Sits between the control units and the `ula` datapath; the `ula` stays purely combinational, outside this block.

Parameters:
- LARGURA, 16, operand/result width in bits; must match the attached `ula`.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- req0  input  1  porta 0 request; level, held until done0
- a0  input  LARGURA  porta 0 operand A
- b0  input  LARGURA  porta 0 operand B
- sel0  input  1  porta 0 operation select (0 = A+B, 1 = A-B)
- done0  output  1  one-cycle pulse; resultado is valid for porta 0
- req1  input  1  porta 1 request
- a1  input  LARGURA  porta 1 operand A
- b1  input  LARGURA  porta 1 operand B
- sel1  input  1  porta 1 operation select
- done1  output  1  one-cycle pulse; resultado is valid for porta 1
- resultado  output  LARGURA  registered ULA result; holds until the next capture
- ocupado  output  1  high whenever state != OCIOSO
- ula_a  output  LARGURA  registered operand A to `ula`
- ula_b  output  LARGURA  registered operand B to `ula`
- ula_sel  output  1  registered select to `ula`
- ula_saida  input  LARGURA  `ula` result (combinational from ula_a/ula_b/ula_sel)

Behaviour:
- One clock domain (clk). Synchronous active-high reset (rst): every state change is on the rising edge of clk.
- Reset values: state=OCIOSO, ultimo=1 (porta 0 wins first), ula_a=0, ula_b=0, ula_sel=0, resultado=0, done0=0, done1=0, ocupado=0.
- FSM states: OCIOSO, EXECUTA, RESPONDE.
- OCIOSO, no request: stays in OCIOSO; registers hold.
- OCIOSO, exactly one req high: grant that port.
- OCIOSO, both req high: grant the port != ultimo.
- On grant, at the edge:
  - ula_a/ula_b/ula_sel <= winner's a/b/sel;
  - vencedor <= winner;
  - state -> EXECUTA.
- EXECUTA: the `ula` settles. At the edge, resultado <= ula_saida and state -> RESPONDE.
- RESPONDE:
  - done[vencedor]=1 for exactly this cycle; the other done stays 0.
  - At the edge: ultimo <= vencedor, state -> OCIOSO.
- Latency: req sampled high in OCIOSO at cycle N -> done high in cycle N+2. Throughput is 1 operation per 3 cycles.
- Requester protocol:
  - a/b/sel need only be stable in the grant cycle; they are latched there.
  - The requester lowers req in the cycle after done, or keeps req high to issue a new operation.
  - A req still high in OCIOSO is treated as a new request.
- Starvation: with both ports requesting continuously, grants strictly alternate 0,1,0,1...
- Arithmetic: add/sub are performed by `ula`, modulo 2^LARGURA. No carry or overflow flag; wrap-around is passed through unchanged.
- req dropped after grant: the operation completes anyway; done still pulses.
- rst mid-operation:
  - Immediate return to OCIOSO with all reset values; no done is emitted for the aborted operation.
  - A still-high req is re-arbitrated from the first cycle with rst low.
- ula_a/ula_b/ula_sel change only on grant edges; resultado changes only on EXECUTA edges.

Optional Feature:
- Macro ULA_ARB_PRIORIDADE_FIXA_EN.
- Defined: fixed priority. porta 0 always wins when both request; ultimo is unused and porta 1 may starve.
- Not defined: round-robin as above.
- All other timing is identical in both builds.

Test Plan:
- Single add: rst 2 cycles; req0=1, a0=0x0002, b0=0x0003, sel0=0 -> ula_a=2, ula_b=3 one edge later; done0 pulses 2 cycles after the grant cycle with resultado=0x0005; done1 stays 0.
- Single subtract: req1=1, a1=0x0004, b1=0x0002, sel1=1 -> done1 pulse, resultado=0x0002; ocupado high for exactly 2 cycles.
- Contention: req0 and req1 held high from reset, porta 0 = 2+3, porta 1 = 4-2 -> done0 (0x0005), done1 (0x0002), done0, done1 ...; consecutive done pulses are 3 cycles apart.
- Wrap-around: a0=0xFFFF, b0=0x0001, sel0=0 -> resultado=0x0000; then a0=0x0000, b0=0x0001, sel0=1 -> resultado=0xFFFF.
- Reset mid-op: grant porta 0, assert rst in EXECUTA -> no done0; resultado=0 and ocupado=0 the cycle after; req0 still high is served normally with a new done0.
- With ULA_ARB_PRIORIDADE_FIXA_EN: both ports requesting continuously -> only done0 pulses, every 3 cycles; done1 never pulses.
